recovery_ctrl: RTL and testbench
================================

Name: recovery_ctrl

Overview:
- Sequences branch-mispredict recovery after the retire stage flags a mispredicted head branch.
- Stalls retire, then pulses a pipeline-wide flush, then restores the speculative map table from the architectural map in fixed-width beats, then issues a fetch redirect with a valid/ready handshake.
- Also latches a committed halt.
- Sits between retire and the ROB, map tables and fetch.

Parameters:
- ARCH_COUNT, `ARCH_REG_SZ (32), number of architectural registers to restore.
- RESTORE_W, `N, map entries copied per restore beat.
- NUM_BEATS, localparam ceil(ARCH_COUNT/RESTORE_W), number of restore beats.
- CNT_W, 32, width of the mispredict statistics counter.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low (0 = reset asserted).
- rob_mispredict  in  1  retire found a mispredicted head branch this cycle.
- mispred_rob_idx  in  ROB_IDX  ROB index of that branch.
- mispred_target  in  ADDR  correct next PC for that branch.
- halt_commit  in  1  a halt instruction retired this cycle.
- retire_stall  out  1  blocks retire from committing.
- flush_o  out  1  one-cycle flush pulse to ROB, RS and map tables.
- flush_rob_idx  out  ROB_IDX  branch index; entries younger than it are squashed.
- restore_en  out  1  map table copies the arch map into the spec map this cycle.
- restore_base  out  REG_IDX  first arch register of the current beat.
- restore_mask  out  RESTORE_W  lane i copies register restore_base+i.
- redirect_valid  out  1  fetch redirect request.
- redirect_pc  out  ADDR  redirect target.
- redirect_ready  in  1  fetch accepts the redirect.
- busy  out  1  state is not IDLE.
- halted  out  1  sticky halt.
- mispred_count  out  CNT_W  number of recoveries started.

Behaviour:
- Reset (reset==0, asynchronous):
  - state=IDLE, beat=0.
  - Captured index and target are 0.
  - mispred_count=0.
  - Every output is 0.
- Reset asserted mid-recovery aborts the sequence immediately; no partial outputs persist.
- States: IDLE, FLUSH, RESTORE, REDIRECT, HALTED. The state is registered; all outputs decode from registered state.
- IDLE:
  - halt_commit=1 -> HALTED. Halt wins over a same-cycle rob_mispredict because the halt is older; the mispredict is dropped and not counted.
  - Else rob_mispredict=1 -> capture mispred_rob_idx and mispred_target, increment mispred_count (saturating at all-ones), go to FLUSH.
- FLUSH (exactly 1 cycle):
  - flush_o=1, flush_rob_idx=captured index.
  - Next state RESTORE with beat=0.
- RESTORE (NUM_BEATS cycles):
  - restore_en=1, restore_base=beat*RESTORE_W.
  - restore_mask[i]=(restore_base+i < ARCH_COUNT); this zeroes unused lanes of a partial last beat.
  - beat increments each cycle. After beat NUM_BEATS-1, beat clears and the state moves to REDIRECT.
- REDIRECT:
  - redirect_valid=1, redirect_pc=captured target, both held stable until redirect_ready.
  - On the cycle valid&&ready both equal 1 -> IDLE. redirect_valid deasserts the next cycle.
- HALTED: terminal until reset. No recovery starts.
- retire_stall = busy = (state != IDLE). In the cycle rob_mispredict arrives, state is still IDLE, so retire commits the branch itself; the stall starts the following cycle.
- rob_mispredict or halt_commit while not IDLE is ignored. The bench flags this as an assertion failure.
- Latency, mispredict at cycle t with ARCH_COUNT=32, RESTORE_W=4 and redirect_ready held high:
  - flush_o at t+1.
  - restore beats t+2..t+9.
  - redirect_valid at t+10.
  - IDLE at t+11, so retire_stall deasserts at t+11.
- Back-to-back: a new mispredict may be accepted in the first IDLE cycle after REDIRECT.

Decomposition:
- sys_defs.svh (shared package): RECOV_STATE enum (IDLE, FLUSH, RESTORE, REDIRECT, HALTED). Existing ADDR, ROB_IDX and REG_IDX are reused.
- NUM_BEATS stays a module-local localparam.
- No sub-module is needed: one FSM, a beat counter, capture registers and a saturating counter.

Test Plan:
- Mispredict idx=5, target=0x1000, ready=1 -> flush_o at t+1 with flush_rob_idx=5; restore_base 0,4,…,28 at t+2..t+9 with mask 4'b1111; redirect_pc=0x1000 at t+10; busy=0 at t+11; mispred_count=1.
- ARCH_COUNT=30, RESTORE_W=4 -> 8 beats; last beat restore_base=28, restore_mask=4'b0011.
- Hold redirect_ready=0 for 5 cycles -> redirect_valid and redirect_pc stay stable, retire_stall stays 1; IDLE one cycle after ready=1.
- Same-cycle halt_commit and rob_mispredict -> HALTED, halted=1, flush_o never pulses, mispred_count unchanged; a later mispredict is ignored.
- reset=0 during RESTORE beat 3 -> all outputs 0 immediately; after release, IDLE with busy=0 and mispred_count=0.
- Preload mispred_count to all-ones, then mispredict -> the count stays all-ones and recovery proceeds normally.

Source files
------------

// File: rtl/recovery_ctrl_pkg.sv
// Shared types for branch-mispredict recovery: state encoding, address and index widths.
package recovery_ctrl_pkg;

  localparam int ARCH_REG_SZ = 32;
  localparam int ADDR_W      = 32;
  localparam int ROB_IDX_W   = 5;
  localparam int REG_IDX_W   = $clog2(ARCH_REG_SZ);

  typedef logic [ADDR_W-1:0]    addr_t;
  typedef logic [ROB_IDX_W-1:0] rob_idx_t;
  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  typedef enum logic [2:0] {
    IDLE,
    FLUSH,
    RESTORE,
    REDIRECT,
    HALTED
  } recov_state_e;

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/recovery_ctrl.sv
// Mispredict recovery sequencer: stall retire, flush, restore spec map from arch map
// in beats, then hand a redirect to fetch. A retired halt parks the block until reset.
module recovery_ctrl
  import recovery_ctrl_pkg::*;
#(
  parameter int ARCH_COUNT = ARCH_REG_SZ,
  parameter int RESTORE_W  = 4,
  parameter int CNT_W      = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 rob_mispredict,
  input  rob_idx_t             mispred_rob_idx,
  input  addr_t                mispred_target,
  input  logic                 halt_commit,
  output logic                 retire_stall,
  output logic                 flush_o,
  output rob_idx_t             flush_rob_idx,
  output logic                 restore_en,
  output reg_idx_t             restore_base,
  output logic [RESTORE_W-1:0] restore_mask,
  output logic                 redirect_valid,
  output addr_t                redirect_pc,
  input  logic                 redirect_ready,
  output logic                 busy,
  output logic                 halted,
  output logic [CNT_W-1:0]     mispred_count
);

  localparam int NUM_BEATS = ceil_div(ARCH_COUNT, RESTORE_W);
  localparam int BEAT_W    = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_BEATS - 1);

  recov_state_e      state_q, state_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  rob_idx_t          idx_q, idx_d;
  addr_t             target_q, target_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [31:0]       beat_base;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      beat_q   <= '0;
      idx_q    <= '0;
      target_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      idx_q    <= idx_d;
      target_q <= target_d;
      count_q  <= count_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    idx_d    = idx_q;
    target_d = target_q;
    count_d  = count_q;
    unique case (state_q)
      IDLE: begin
        // A same-cycle halt is older than the branch, so the mispredict is dropped.
        if (halt_commit) begin
          state_d = HALTED;
        end else if (rob_mispredict) begin
          idx_d    = mispred_rob_idx;
          target_d = mispred_target;
          count_d  = (count_q == '1) ? count_q : count_q + CNT_W'(1);
          state_d  = FLUSH;
        end
      end
      FLUSH: begin
        beat_d  = '0;
        state_d = RESTORE;
      end
      RESTORE: begin
        if (beat_q == LAST_BEAT) begin
          beat_d  = '0;
          state_d = REDIRECT;
        end else begin
          beat_d = beat_q + BEAT_W'(1);
        end
      end
      REDIRECT: begin
        if (redirect_ready) state_d = IDLE;
      end
      HALTED:  state_d = HALTED;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode purely from registered state, so an async reset clears them at once.
  assign busy           = (state_q != IDLE);
  assign retire_stall   = busy;
  assign halted         = (state_q == HALTED);
  assign flush_o        = (state_q == FLUSH);
  assign flush_rob_idx  = flush_o ? idx_q : '0;
  assign restore_en     = (state_q == RESTORE);
  assign beat_base      = 32'(beat_q) * 32'(RESTORE_W);
  assign restore_base   = restore_en ? reg_idx_t'(beat_base) : '0;
  assign redirect_valid = (state_q == REDIRECT);
  assign redirect_pc    = redirect_valid ? target_q : '0;
  assign mispred_count  = count_q;

  // Lanes past ARCH_COUNT are masked off on a partial final beat.
  for (genvar gi = 0; gi < RESTORE_W; gi++) begin : g_lane
    assign restore_mask[gi] = restore_en && ((beat_base + 32'(gi)) < 32'(ARCH_COUNT));
  end

endmodule

// File: tb/tb_recovery_ctrl.sv
// Bench for recovery_ctrl: two instances (32 regs / 32-bit count, 30 regs / 2-bit count)
// share stimulus and are checked against a timeline model of the recovery sequence.
module tb_recovery_ctrl;

  localparam int NB = 8;
  localparam int W  = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        rob_mispredict;
  logic [4:0]  mispred_rob_idx;
  logic [31:0] mispred_target;
  logic        halt_commit;
  logic        redirect_ready;

  logic        a_stall, a_flush, a_ren, a_rv, a_busy, a_halted;
  logic [4:0]  a_fidx, a_rbase;
  logic [3:0]  a_rmask;
  logic [31:0] a_rpc, a_cnt;
  logic        b_stall, b_flush, b_ren, b_rv, b_busy, b_halted;
  logic [4:0]  b_fidx, b_rbase;
  logic [3:0]  b_rmask;
  logic [31:0] b_rpc;
  logic [1:0]  b_cnt;

  int checks = 0;
  int errors = 0;

  // Model: mode 0 idle, 1 recovering, 2 halted; m_k = cycles since the mispredict was taken.
  int          m_mode = 0;
  int          m_k = 0;
  logic [4:0]  m_idx = '0;
  logic [31:0] m_tgt = '0;
  logic [31:0] m_cnt_a = '0;
  logic [1:0]  m_cnt_b = '0;

  always #5 clock = ~clock;

  recovery_ctrl #(.ARCH_COUNT(32), .RESTORE_W(4), .CNT_W(32)) dut_a (
    .clock(clock), .reset(reset), .rob_mispredict(rob_mispredict),
    .mispred_rob_idx(mispred_rob_idx), .mispred_target(mispred_target),
    .halt_commit(halt_commit), .retire_stall(a_stall), .flush_o(a_flush),
    .flush_rob_idx(a_fidx), .restore_en(a_ren), .restore_base(a_rbase),
    .restore_mask(a_rmask), .redirect_valid(a_rv), .redirect_pc(a_rpc),
    .redirect_ready(redirect_ready), .busy(a_busy), .halted(a_halted),
    .mispred_count(a_cnt));

  recovery_ctrl #(.ARCH_COUNT(30), .RESTORE_W(4), .CNT_W(2)) dut_b (
    .clock(clock), .reset(reset), .rob_mispredict(rob_mispredict),
    .mispred_rob_idx(mispred_rob_idx), .mispred_target(mispred_target),
    .halt_commit(halt_commit), .retire_stall(b_stall), .flush_o(b_flush),
    .flush_rob_idx(b_fidx), .restore_en(b_ren), .restore_base(b_rbase),
    .restore_mask(b_rmask), .redirect_valid(b_rv), .redirect_pc(b_rpc),
    .redirect_ready(redirect_ready), .busy(b_busy), .halted(b_halted),
    .mispred_count(b_cnt));

  wire [51:0] act_pipe_a = {a_stall, a_flush, a_fidx, a_ren, a_rbase, a_rmask, a_rv, a_rpc, a_busy, a_halted};
  wire [51:0] act_pipe_b = {b_stall, b_flush, b_fidx, b_ren, b_rbase, b_rmask, b_rv, b_rpc, b_busy, b_halted};

  function automatic logic [51:0] exp_pipe(input int arch);
    logic        bz, hl, fl, ren, rv;
    logic [4:0]  fidx, base;
    logic [3:0]  mask;
    logic [31:0] pc;
    bz   = (m_mode != 0);
    hl   = (m_mode == 2);
    fl   = (m_mode == 1) && (m_k == 1);
    ren  = (m_mode == 1) && (m_k >= 2) && (m_k <= NB + 1);
    rv   = (m_mode == 1) && (m_k >= NB + 2);
    fidx = fl ? m_idx : 5'd0;
    base = ren ? 5'((m_k - 2) * W) : 5'd0;
    for (int i = 0; i < W; i++) mask[i] = ren && (((m_k - 2) * W + i) < arch);
    pc   = rv ? m_tgt : 32'd0;
    return {bz, fl, fidx, ren, base, mask, rv, pc, bz, hl};
  endfunction

  task automatic model_step();
    if (m_mode == 1 && (rob_mispredict || halt_commit)) begin
      errors++;
      $display("FAIL protocol: event while recovering mispredict=%0b halt=%0b required none", rob_mispredict, halt_commit);
    end
    if (m_mode == 0) begin
      if (halt_commit) begin
        m_mode = 2;
      end else if (rob_mispredict) begin
        m_mode = 1; m_k = 1;
        m_idx = mispred_rob_idx; m_tgt = mispred_target;
        if (m_cnt_a != 32'hFFFF_FFFF) m_cnt_a = m_cnt_a + 1;
        if (m_cnt_b != 2'b11) m_cnt_b = m_cnt_b + 1;
        $display("recovery start idx=%0d target=%h", m_idx, m_tgt);
      end
    end else if (m_mode == 1) begin
      if (m_k >= NB + 2) begin
        if (redirect_ready) m_mode = 0;
      end else begin
        m_k++;
      end
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; rob_mispredict = 0; halt_commit = 0; redirect_ready = 0;
    mispred_rob_idx = '0; mispred_target = '0;
    #1 reset = 1'b0;
    #1;
    checks++;
    if ({act_pipe_a, a_cnt, act_pipe_b, b_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_outputs act_a=%h act_b=%h required 0", {act_pipe_a, a_cnt}, {act_pipe_b, b_cnt});
    end
    @(posedge clock); @(posedge clock); #1 reset = 1'b1;
    tick();
    checks++;
    if ({act_pipe_a, a_cnt} !== {exp_pipe(32), m_cnt_a} || a_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle act=%h exp=%h", {act_pipe_a, a_cnt}, {exp_pipe(32), m_cnt_a});
    end
  endtask

  task automatic test_latency();
    logic ef, er, ev, eb;
    rob_mispredict = 1; mispred_rob_idx = 5'd5; mispred_target = 32'h1000; redirect_ready = 1;
    tick();
    rob_mispredict = 0;
    for (int k = 1; k <= 11; k++) begin
      ef = (k == 1); er = (k >= 2 && k <= 9); ev = (k == 10); eb = (k <= 10);
      checks++;
      if ({a_flush, a_ren, a_rv, a_busy, a_stall} !== {ef, er, ev, eb, eb}) begin
        errors++;
        $display("FAIL latency_timing t+%0d act=%b exp=%b", k, {a_flush, a_ren, a_rv, a_busy, a_stall}, {ef, er, ev, eb, eb});
      end
      checks++;
      if ((ef && a_fidx !== 5'd5) || (er && (a_rbase !== 5'((k - 2) * 4) || a_rmask !== 4'b1111)) ||
          (ev && a_rpc !== 32'h1000)) begin
        errors++;
        $display("FAIL latency_values t+%0d idx=%0d base=%0d mask=%b pc=%h", k, a_fidx, a_rbase, a_rmask, a_rpc);
      end
      checks++;
      if ({act_pipe_a, a_cnt} !== {exp_pipe(32), m_cnt_a}) begin
        errors++;
        $display("FAIL latency_model t+%0d act=%h exp=%h", k, {act_pipe_a, a_cnt}, {exp_pipe(32), m_cnt_a});
      end
      if (k < 11) tick();
    end
    checks++;
    if (a_cnt !== 32'd1) begin
      errors++;
      $display("FAIL latency_count act=%0d required 1", a_cnt);
    end
  endtask

  task automatic test_partial_beat();
    rob_mispredict = 1; mispred_rob_idx = 5'd17; mispred_target = 32'hCAFE_0040; redirect_ready = 1;
    tick();
    rob_mispredict = 0;
    for (int k = 1; k <= 11; k++) begin
      checks++;
      if ({act_pipe_b, b_cnt} !== {exp_pipe(30), m_cnt_b}) begin
        errors++;
        $display("FAIL partial_model t+%0d act=%h exp=%h", k, {act_pipe_b, b_cnt}, {exp_pipe(30), m_cnt_b});
      end
      if (k == 9) begin
        checks++;
        if (b_rbase !== 5'd28 || b_rmask !== 4'b0011 || b_ren !== 1'b1 || a_rmask !== 4'b1111) begin
          errors++;
          $display("FAIL partial_last_beat base=%0d mask=%b a_mask=%b required 28 0011 1111", b_rbase, b_rmask, a_rmask);
        end
      end
      if (k < 11) tick();
    end
  endtask

  task automatic test_redirect_hold();
    logic [31:0] tgt;
    tgt = $urandom;
    rob_mispredict = 1; mispred_rob_idx = 5'd9; mispred_target = tgt; redirect_ready = 0;
    tick();
    rob_mispredict = 0; mispred_target = ~tgt;
    for (int k = 1; k < 10; k++) tick();
    for (int h = 0; h <= 5; h++) begin
      checks++;
      if (a_rv !== 1'b1 || a_rpc !== tgt || a_stall !== 1'b1 || b_rv !== 1'b1 || b_rpc !== tgt) begin
        errors++;
        $display("FAIL hold_redirect h=%0d valid=%b pc=%h stall=%b required 1 %h 1", h, a_rv, a_rpc, a_stall, tgt);
      end
      if (h < 5) tick();
    end
    redirect_ready = 1;
    tick();
    checks++;
    if (a_busy !== 1'b0 || a_rv !== 1'b0 || a_stall !== 1'b0 || {act_pipe_b, b_cnt} !== {exp_pipe(30), m_cnt_b}) begin
      errors++;
      $display("FAIL hold_release busy=%b valid=%b stall=%b required 0 0 0", a_busy, a_rv, a_stall);
    end
  endtask

  task automatic test_back_to_back();
    rob_mispredict = 1; mispred_rob_idx = 5'd3; mispred_target = 32'h2000; redirect_ready = 1;
    tick();
    rob_mispredict = 0;
    for (int c = 0; c < 40 && m_mode != 0; c++) begin
      checks++;
      if ({act_pipe_a, a_cnt} !== {exp_pipe(32), m_cnt_a}) begin
        errors++;
        $display("FAIL b2b_first c=%0d act=%h exp=%h", c, {act_pipe_a, a_cnt}, {exp_pipe(32), m_cnt_a});
      end
      tick();
    end
    checks++;
    if (m_mode != 0 || a_busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle busy=%b required 0", a_busy);
    end
    rob_mispredict = 1; mispred_rob_idx = 5'd30; mispred_target = 32'h3000;
    tick();
    rob_mispredict = 0;
    checks++;
    if (a_flush !== 1'b1 || a_fidx !== 5'd30 || b_flush !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second flush=%b idx=%0d required 1 30", a_flush, a_fidx);
    end
    for (int c = 0; c < 40 && m_mode != 0; c++) tick();
  endtask

  task automatic test_saturate();
    for (int r = 0; r < 2; r++) begin
      rob_mispredict = 1; mispred_rob_idx = 5'($urandom); mispred_target = $urandom; redirect_ready = 1;
      tick();
      rob_mispredict = 0;
      checks++;
      if (b_cnt !== 2'b11 || b_flush !== 1'b1 || a_cnt !== m_cnt_a) begin
        errors++;
        $display("FAIL saturate r=%0d cnt_b=%0d flush_b=%b cnt_a=%0d required 3 1 %0d", r, b_cnt, b_flush, a_cnt, m_cnt_a);
      end
      for (int c = 0; c < 40 && m_mode != 0; c++) begin
        checks++;
        if ({act_pipe_b, b_cnt} !== {exp_pipe(30), m_cnt_b}) begin
          errors++;
          $display("FAIL saturate_model c=%0d act=%h exp=%h", c, {act_pipe_b, b_cnt}, {exp_pipe(30), m_cnt_b});
        end
        tick();
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rob_mispredict  = (m_mode == 0) && ($urandom_range(0, 3) == 0);
      mispred_rob_idx = 5'($urandom);
      mispred_target  = $urandom;
      redirect_ready  = ($urandom_range(0, 2) != 0);
      tick();
      checks++;
      if ({act_pipe_a, a_cnt} !== {exp_pipe(32), m_cnt_a}) begin
        errors++;
        $display("FAIL random_a c=%0d act=%h exp=%h", c, {act_pipe_a, a_cnt}, {exp_pipe(32), m_cnt_a});
      end
      checks++;
      if ({act_pipe_b, b_cnt} !== {exp_pipe(30), m_cnt_b}) begin
        errors++;
        $display("FAIL random_b c=%0d act=%h exp=%h", c, {act_pipe_b, b_cnt}, {exp_pipe(30), m_cnt_b});
      end
    end
    rob_mispredict = 0; redirect_ready = 1;
    for (int c = 0; c < 40 && m_mode != 0; c++) tick();
    checks++;
    if (m_mode != 0 || a_busy !== 1'b0) begin
      errors++;
      $display("FAIL random_drain busy=%b required 0", a_busy);
    end
  endtask

  task automatic test_reset_mid();
    rob_mispredict = 1; mispred_rob_idx = 5'd12; mispred_target = 32'h4444; redirect_ready = 1;
    tick();
    rob_mispredict = 0;
    while (m_k < 5) tick();
    checks++;
    if (a_ren !== 1'b1 || a_rbase !== 5'd12) begin
      errors++;
      $display("FAIL midreset_beat3 en=%b base=%0d required 1 12", a_ren, a_rbase);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({act_pipe_a, a_cnt, act_pipe_b, b_cnt} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs act_a=%h act_b=%h required 0", {act_pipe_a, a_cnt}, {act_pipe_b, b_cnt});
    end
    m_mode = 0; m_k = 0; m_idx = '0; m_tgt = '0; m_cnt_a = '0; m_cnt_b = '0;
    #2 reset = 1'b1;
    tick();
    checks++;
    if (a_busy !== 1'b0 || a_cnt !== 32'd0 || {act_pipe_b, b_cnt} !== '0) begin
      errors++;
      $display("FAIL midreset_release busy=%b cnt=%0d required 0 0", a_busy, a_cnt);
    end
  endtask

  task automatic test_halt();
    rob_mispredict = 1; halt_commit = 1; mispred_rob_idx = 5'd7; mispred_target = 32'h5000;
    tick();
    rob_mispredict = 0; halt_commit = 0;
    for (int c = 0; c < 8; c++) begin
      checks++;
      if (a_halted !== 1'b1 || a_flush !== 1'b0 || b_flush !== 1'b0 || a_cnt !== 32'd0 ||
          {act_pipe_a, a_cnt} !== {exp_pipe(32), m_cnt_a}) begin
        errors++;
        $display("FAIL halt c=%0d halted=%b flush=%b cnt=%0d required 1 0 0", c, a_halted, a_flush, a_cnt);
      end
      rob_mispredict = (c == 3);
      tick();
    end
    rob_mispredict = 0;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_partial_beat();
    test_redirect_hold();
    test_back_to_back();
    test_saturate();
    test_random();
    test_reset_mid();
    test_halt();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
